// File: rtl/spi_slave_seq_if.sv
// spi_slave_seq_if: SPI pin and data-memory signal bundle for spi_slave_seq
//   slave modport  : the sequencer's view (SPI pins in, memory strobes out)
//   master modport : the view of whoever drives the SPI pins and serves memory reads
interface spi_slave_seq_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              sclk, cs, mosi, miso, miso_oe;
  logic              dm_we, rd_req, busy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  modport slave (
    input  sclk, cs, mosi, rdata,
    output miso, miso_oe, addr, wdata, dm_we, rd_req, busy
  );
  modport master (
    output sclk, cs, mosi, rdata,
    input  miso, miso_oe, addr, wdata, dm_we, rd_req, busy
  );
endinterface

// File: rtl/spi_slave_seq.sv
// spi_slave_seq: mode-0 SPI slave sequencer; decodes an address/RW header and drives data-memory strobes and MISO
//   clk      system clock, at least 8x the sclk frequency
//   reset_n  asynchronous active-low reset
//   bus      slave modport: sclk/cs/mosi/rdata in; miso/miso_oe/addr/wdata/dm_we/rd_req/busy out
module spi_slave_seq #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int BURST       = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  spi_slave_seq_if.slave bus
);
  localparam int CNT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  typedef enum logic [2:0] {IDLE, ADDR, RD_REQ, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic                   sclk_d;
  logic [CNT_W-1:0]       bit_cnt;
  logic [ADDR_W-1:0]      hdr_sr;
  logic [DATA_W-2:0]      wr_sr;
  logic [DATA_W-1:0]      tx_sr;
  logic                   sclk_s, cs_s, mosi_s, rise, fall, last_hdr, last_word;
  logic [ADDR_W:0]        hdr_nx;
  logic [DATA_W-1:0]      wr_nx;
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  // shift registers keep only the history; the bit arriving on this rise completes the word
  assign hdr_nx    = {hdr_sr, mosi_s};
  assign wr_nx     = {wr_sr, mosi_s};
  assign last_hdr  = bit_cnt == CNT_W'(ADDR_W);
  assign last_word = bit_cnt == CNT_W'(DATA_W - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      sclk_d      <= 1'b0;
      state       <= IDLE;
      bit_cnt     <= '0;
      hdr_sr      <= '0;
      wr_sr       <= '0;
      tx_sr       <= '0;
      bus.miso    <= 1'b0;
      bus.miso_oe <= 1'b0;
      bus.addr    <= '0;
      bus.wdata   <= '0;
      bus.dm_we   <= 1'b0;
      bus.rd_req  <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
      cs_q       <= {cs_q[SYNC_STAGES-2:0], bus.cs};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_d     <= sclk_s;
      bus.dm_we  <= 1'b0;
      bus.rd_req <= 1'b0;
      // a dm_we already high in WR_COMMIT still completes this cycle; anything partial is dropped
      if (cs_s && state != IDLE) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        bus.miso_oe <= 1'b0;
        bus.busy    <= 1'b0;
      end else
        case (state)
          IDLE:
            if (!cs_s) begin
              state    <= ADDR;
              bit_cnt  <= '0;
              bus.busy <= 1'b1;
            end
          ADDR:
            if (rise) begin
              hdr_sr <= hdr_nx[ADDR_W-1:0];
              if (last_hdr) begin
                bus.addr   <= hdr_nx[ADDR_W:1];
                bit_cnt    <= '0;
                bus.rd_req <= hdr_nx[0];
                state      <= hdr_nx[0] ? RD_REQ : WR_SHIFT;
              end else
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
          RD_REQ:
            state <= RD_LOAD;
          RD_LOAD: begin
            tx_sr       <= bus.rdata;
            bus.miso_oe <= 1'b1;
            state       <= RD_SHIFT;
          end
          RD_SHIFT: begin
            if (fall) begin
              bus.miso <= tx_sr[DATA_W-1];
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            // in burst mode the next word is fetched before the following fall so no gap bit appears
            if (rise) begin
              if (last_word) begin
                bit_cnt <= '0;
                if (BURST != 0) begin
                  bus.addr   <= bus.addr + ADDR_W'(1);
                  bus.rd_req <= 1'b1;
                  state      <= RD_REQ;
                end else
                  state <= DONE;
              end else
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          WR_SHIFT:
            if (rise) begin
              wr_sr <= wr_nx[DATA_W-2:0];
              if (last_word) begin
                bus.wdata <= wr_nx;
                bus.dm_we <= 1'b1;
                bit_cnt   <= '0;
                state     <= WR_COMMIT;
              end else
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
          WR_COMMIT:
            if (BURST != 0) begin
              bus.addr <= bus.addr + ADDR_W'(1);
              state    <= WR_SHIFT;
            end else
              state <= DONE;
          DONE:
            state <= DONE;
          default:
            state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_slave_seq.sv
// tb_spi_slave_seq: scoreboard bench for spi_slave_seq (single, burst-wrap, burst-read, abort, reset-mid-read)
module tb_spi_slave_seq;
  localparam int HALF = 80;
  logic clk = 1'b0, reset_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic [2:0] cs_v = 3'b111;
  logic [7:0] rmem [128];
  int checks = 0, failures = 0;
  logic [17:0] wq[$];
  logic [9:0]  rq[$];
  logic [2:0]  bq[$];

  spi_slave_seq_if #(.ADDR_W(7), .DATA_W(8)) i0 ();
  spi_slave_seq_if #(.ADDR_W(4), .DATA_W(8)) i1 ();
  spi_slave_seq_if #(.ADDR_W(7), .DATA_W(8)) i2 ();
  spi_slave_seq #(.ADDR_W(7), .DATA_W(8), .BURST(0), .SYNC_STAGES(2)) d0 (.clk(clk), .reset_n(reset_n), .bus(i0.slave));
  spi_slave_seq #(.ADDR_W(4), .DATA_W(8), .BURST(1), .SYNC_STAGES(2)) d1 (.clk(clk), .reset_n(reset_n), .bus(i1.slave));
  spi_slave_seq #(.ADDR_W(7), .DATA_W(8), .BURST(1), .SYNC_STAGES(2)) d2 (.clk(clk), .reset_n(reset_n), .bus(i2.slave));

  always #5 clk = ~clk;
  assign i0.sclk = sclk;
  assign i1.sclk = sclk;
  assign i2.sclk = sclk;
  assign i0.mosi = mosi;
  assign i1.mosi = mosi;
  assign i2.mosi = mosi;
  assign i0.cs = cs_v[0];
  assign i1.cs = cs_v[1];
  assign i2.cs = cs_v[2];
  assign i1.rdata = 8'h00;
  always @(posedge clk) if (i0.rd_req) i0.rdata <= rmem[i0.addr];
  always @(posedge clk) if (i2.rd_req) i2.rdata <= rmem[i2.addr];

  logic [2:0] we_v, rq_v, oe_v, miso_v, busy_v;
  logic [2:0][7:0] addr_v, wd_v;
  assign we_v   = {i2.dm_we, i1.dm_we, i0.dm_we};
  assign rq_v   = {i2.rd_req, i1.rd_req, i0.rd_req};
  assign oe_v   = {i2.miso_oe, i1.miso_oe, i0.miso_oe};
  assign miso_v = {i2.miso, i1.miso, i0.miso};
  assign busy_v = {i2.busy, i1.busy, i0.busy};
  assign addr_v = {{1'b0, i2.addr}, {4'h0, i1.addr}, {1'b0, i0.addr}};
  assign wd_v   = {i2.wdata, i1.wdata, i0.wdata};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s act=%0h exp=none", nm, act);
  endtask

  // memory-side monitor: every strobe must match the oldest expectation
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      if (we_v[k]) begin
        if (wq.size() == 0) bad("dm_we_unexpected", 32'({2'(k), addr_v[k], wd_v[k]}));
        else chk("dm_we_addr_data", 32'({2'(k), addr_v[k], wd_v[k]}), 32'(wq.pop_front()));
      end
      if (rq_v[k]) begin
        if (rq.size() == 0) bad("rd_req_unexpected", 32'({2'(k), addr_v[k]}));
        else chk("rd_req_addr", 32'({2'(k), addr_v[k]}), 32'(rq.pop_front()));
      end
    end

  // master-side monitor: MISO is sampled on every sclk rise while driven
  always @(posedge sclk)
    for (int k = 0; k < 3; k++)
      if (oe_v[k]) begin
        if (bq.size() == 0) bad("miso_unexpected", 32'({2'(k), miso_v[k]}));
        else chk("miso_bit", 32'({2'(k), miso_v[k]}), 32'(bq.pop_front()));
      end

  task automatic push_bits(input int k, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bq.push_back({2'(k), v[i]});
  endtask

  task automatic send(input int n, input logic [63:0] b);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = b[i];
      #HALF sclk = 1'b1;
      #HALF sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (busy_v[k] && n < 20);
    chk("busy_drop_within_3clk", 32'(n <= 3), 32'd1);
    chk("oe_after_cs", 32'(oe_v[k]), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input int k, input int n, input logic [63:0] b, input logic exp_oe);
    cs_v[k] = 1'b0;
    #HALF send(n, b);
    #HALF chk("busy_in_frame", 32'(busy_v[k]), 32'd1);
    chk("oe_in_frame", 32'(oe_v[k]), 32'(exp_oe));
    cs_v[k] = 1'b1;
    wait_idle(k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) rmem[i] = 8'(i);
    rmem[7'h05] = 8'h96;
    rmem[7'h10] = 8'hA5;
    rmem[7'h11] = 8'h3C;
    rmem[7'h12] = 8'h77;
    #2 reset_n = 1'b0;
    #30;
    chk("rst_miso", 32'(i0.miso), 32'd0);
    chk("rst_miso_oe", 32'(i0.miso_oe), 32'd0);
    chk("rst_addr", 32'(i0.addr), 32'd0);
    chk("rst_wdata", 32'(i0.wdata), 32'd0);
    chk("rst_dm_we", 32'(i0.dm_we), 32'd0);
    chk("rst_rd_req", 32'(i0.rd_req), 32'd0);
    chk("rst_busy", 32'(busy_v), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    // single write
    wq.push_back({2'd0, 8'h2A, 8'hC3});
    frame(0, 16, 64'({7'h2A, 1'b0, 8'hC3}), 1'b0);
    // single read
    rq.push_back({2'd0, 8'h05});
    push_bits(0, 8'h96);
    frame(0, 16, 64'({7'h05, 1'b1, 8'h00}), 1'b1);
    // burst write wrapping 0xF -> 0x0 -> 0x1
    wq.push_back({2'd1, 8'h0F, 8'h11});
    wq.push_back({2'd1, 8'h00, 8'h22});
    wq.push_back({2'd1, 8'h01, 8'h33});
    frame(1, 29, 64'({4'hF, 1'b0, 8'h11, 8'h22, 8'h33}), 1'b0);
    // burst read: two words back to back, then the prefetch of the next address
    rq.push_back({2'd2, 8'h10});
    rq.push_back({2'd2, 8'h11});
    rq.push_back({2'd2, 8'h12});
    push_bits(2, 8'hA5);
    push_bits(2, 8'h3C);
    frame(2, 24, 64'({7'h10, 1'b1, 16'h0000}), 1'b1);
    // abort after 5 of 8 data bits, then a normal write
    frame(0, 13, 64'({7'h33, 1'b0, 5'b10110}), 1'b0);
    wq.push_back({2'd0, 8'h33, 8'h5A});
    frame(0, 16, 64'({7'h33, 1'b0, 8'h5A}), 1'b0);
    // reset in the middle of a read
    rq.push_back({2'd0, 8'h05});
    bq.push_back({2'd0, 1'b1});
    bq.push_back({2'd0, 1'b0});
    bq.push_back({2'd0, 1'b0});
    cs_v[0] = 1'b0;
    #HALF send(11, 64'({7'h05, 1'b1, 3'b000}));
    #HALF reset_n = 1'b0;
    #1;
    chk("rstmid_miso_oe", 32'(i0.miso_oe), 32'd0);
    chk("rstmid_busy", 32'(i0.busy), 32'd0);
    chk("rstmid_addr", 32'(i0.addr), 32'd0);
    cs_v[0] = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    rq.push_back({2'd0, 8'h05});
    push_bits(0, 8'h96);
    frame(0, 16, 64'({7'h05, 1'b1, 8'h00}), 1'b1);
    repeat (10) @(negedge clk);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
